// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchronisers, a shared sample-tick prescaler,
// per-key agree/hold counters, registered press/release/long strobes and an LED driver.
`timescale 1ns/1ps
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int SCAN_DIV   = 1000000,
  parameter int STABLE_N   = 3,
  parameter int LONG_TICKS = 50,
  parameter int LED_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] led_out
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]     presc;
  logic              tick;
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] sample;

  assign tick = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + PW'(1);
  end

  // Synchronisers reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign sample = ~sync2;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [3:0] agree;
    logic [3:0] agree_inc;
    logic [9:0] hold;
    logic       hold_at;
    logic       hold_at_d;
    logic       state;
    logic       state_d;
    logic       press_r;
    logic       release_r;
    logic       long_r;
    logic       led_r;

    assign agree_inc = agree + 4'd1;
    assign hold_at   = (hold == 10'(LONG_TICKS));

    always_ff @(posedge clk) begin
      if (rst) begin
        agree <= '0;
        state <= 1'b0;
      end else if (tick) begin
        if (sample[i] != state) begin
          if (agree_inc == 4'(STABLE_N)) begin
            state <= ~state;
            agree <= '0;
          end else begin
            agree <= agree_inc;
          end
        end else begin
          agree <= '0;
        end
      end
    end

    // Hold counter saturates, so hold_at stays high until release and long fires once.
    always_ff @(posedge clk) begin
      if (rst || !state)         hold <= '0;
      else if (tick && !hold_at) hold <= hold + 10'd1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_d   <= 1'b0;
        hold_at_d <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        led_r     <= 1'b0;
      end else begin
        state_d   <= state;
        hold_at_d <= hold_at;
        press_r   <= state & ~state_d;
        release_r <= ~state & state_d;
        long_r    <= hold_at & ~hold_at_d;
        if (LED_MODE == 1) led_r <= state;
        else               led_r <= led_r ^ (state & ~state_d);
      end
    end

    assign key_state[i]     = state;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign long_pulse[i]    = long_r;
    assign led_out[i]       = led_r;
  end

endmodule
